// File: rtl/windowed_register_file.sv
// Windowed register file: 8 globals plus NWINDOWS overlapping
// 16-register windows, CWP/WIM tracking and window traps.
module windowed_register_file #(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 4,
  parameter bit BYPASS   = 1'b0
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic [4:0]                  RA,
  input  logic [4:0]                  RB,
  input  logic [4:0]                  RD,
  output logic [WIDTH-1:0]            PA,
  output logic [WIDTH-1:0]            PB,
  output logic [WIDTH-1:0]            PD,
  input  logic [4:0]                  RW,
  input  logic [WIDTH-1:0]            PW,
  input  logic                        LE,
  input  logic                        Save,
  input  logic                        Restore,
  input  logic                        WimLd,
  input  logic [NWINDOWS-1:0]         WimIn,
  output logic [$clog2(NWINDOWS)-1:0] CWP,
  output logic [NWINDOWS-1:0]         WIM,
  output logic                        TrapOvf,
  output logic                        TrapUnf
);

  localparam int CW    = $clog2(NWINDOWS);
  localparam int PAW   = CW + 5;
  localparam int NPHYS = 8 + 16 * NWINDOWS;

  logic [WIDTH-1:0]    rf [NPHYS];
  logic [CW-1:0]       cwp_q;
  logic [CW-1:0]       cwp_nxt;
  logic [CW-1:0]       tgt_s;
  logic [CW-1:0]       tgt_r;
  logic [NWINDOWS-1:0] wim_q;
  logic                ovf_q;
  logic                unf_q;
  logic                do_save;
  logic                do_rest;
  logic                ovf;
  logic                unf;
  logic                wr_en;
  logic                byp_ok;
  logic [PAW-1:0]      wa;
  logic [PAW-1:0]      aa;
  logic [PAW-1:0]      ab;
  logic [PAW-1:0]      ad;
  logic [WIDTH-1:0]    sa;
  logic [WIDTH-1:0]    sb;
  logic [WIDTH-1:0]    sd;

  // Window offset wraps by truncation since 16*NWINDOWS is a power of two.
  function automatic logic [PAW-1:0] map(
    input logic [4:0]    r,
    input logic [CW-1:0] w
  );
    logic [CW+3:0] off;
    off = {w, 4'b0000} + (CW+4)'(r - 5'd8);
    if (r[4:3] == 2'b00)
      map = {{(CW+2){1'b0}}, r[2:0]};
    else
      map = {1'b0, off} + PAW'(8);
  endfunction

  // Window move decode, trap detection and write qualification.
  always_comb begin
    tgt_s   = cwp_q - CW'(1);
    tgt_r   = cwp_q + CW'(1);
    do_save = Save & ~Restore;
    do_rest = Restore & ~Save;
    ovf     = do_save & wim_q[tgt_s];
    unf     = do_rest & wim_q[tgt_r];
    cwp_nxt = cwp_q;
    unique case (1'b1)
      do_save & ~ovf: cwp_nxt = tgt_s;
      do_rest & ~unf: cwp_nxt = tgt_r;
      default:        cwp_nxt = cwp_q;
    endcase
    wr_en = LE & ~ovf & ~unf & (RW != 5'd0);
    wa    = map(RW, cwp_nxt);
  end

  // Asynchronous read ports with optional write-through forwarding.
  always_comb begin
    aa     = map(RA, cwp_q);
    ab     = map(RB, cwp_q);
    ad     = map(RD, cwp_q);
    sa     = (RA == 5'd0) ? '0 : rf[aa];
    sb     = (RB == 5'd0) ? '0 : rf[ab];
    sd     = (RD == 5'd0) ? '0 : rf[ad];
    byp_ok = BYPASS & LE & (RW != 5'd0) & ~Save & ~Restore;
    PA     = (byp_ok && RA == RW) ? PW : sa;
    PB     = (byp_ok && RB == RW) ? PW : sb;
    PD     = (byp_ok && RD == RW) ? PW : sd;
  end

  // Window pointer, invalid mask and one-cycle trap pulses.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cwp_q <= '0;
      wim_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cwp_q <= cwp_nxt;
      if (WimLd)
        wim_q <= WimIn;
      ovf_q <= ovf;
      unf_q <= unf;
    end
  end

  // Physical register storage; writes map through the post-move CWP.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < NPHYS; i++)
        rf[i] <= '0;
    end else if (wr_en) begin
      rf[wa] <= PW;
    end
  end

  assign CWP     = cwp_q;
  assign WIM     = wim_q;
  assign TrapOvf = ovf_q;
  assign TrapUnf = unf_q;

endmodule

// File: doc/windowed_register_file.md
# windowed_register_file

Parametrised SPARC-style windowed register file: 8 global registers plus `NWINDOWS` overlapping 16-register windows, giving `8 + 16*NWINDOWS` physical registers. It has three asynchronous read ports and one synchronous write port. It keeps the current window pointer (CWP) and window invalid mask (WIM), and raises window overflow/underflow trap pulses. It sits in the datapath between operand select and the ALU, in place of the flat 32-entry file.

## Interface
- `WIDTH`, 32, data width of each register and port.
- `NWINDOWS`, 4, number of register windows; power of two, 2..32.
- `BYPASS`, 0, 1 = write-through forwarding from `PW` to read ports in the write cycle.
- `Clk`  input  1  clock; all state changes on rising edge.
- `Rst_n`  input  1  reset, synchronous, active-low.
- `RA`, `RB`, `RD`  input  5 each  read-port architectural register selectors.
- `PA`, `PB`, `PD`  output  `WIDTH` each  read-port data.
- `RW`  input  5  write architectural register selector.
- `PW`  input  `WIDTH`  write data.
- `LE`  input  1  write enable.
- `Save`  input  1  request CWP decrement.
- `Restore`  input  1  request CWP increment.
- `WimLd`  input  1  load WIM from `WimIn`.
- `WimIn`  input  `NWINDOWS`  new WIM value.
- `CWP`  output  `$clog2(NWINDOWS)`  current window pointer.
- `WIM`  output  `NWINDOWS`  window invalid mask.
- `TrapOvf`  output  1  window overflow pulse.
- `TrapUnf`  output  1  window underflow pulse.

## Operation
- Architectural-to-physical mapping for selector r:
  - r0..r7 map to physical 0..7 (globals, shared by all windows).
  - r8..r31 map to physical `8 + ((16*CWP + (r-8)) mod (16*NWINDOWS))`.
  - r8..r15 are outs, r16..r23 locals, r24..r31 ins.
  - The ins of window w alias the outs of window w+1 (mod `NWINDOWS`).
- r0 always reads 0. Writes to r0 are discarded.
- Reads are combinational from the selectors and CWP.
- Write: when `LE`=1, `PW` is stored to the physical register that `RW` maps to, on the rising edge.
- Save: target = (CWP-1) mod `NWINDOWS`.
  - If `WIM[target]`=1: CWP is unchanged, `TrapOvf`=1 next cycle, and the same-cycle write is suppressed.
  - Otherwise CWP becomes the target.
- Restore: target = (CWP+1) mod `NWINDOWS`.
  - If `WIM[target]`=1: CWP is unchanged, `TrapUnf`=1 next cycle, and the same-cycle write is suppressed.
  - Otherwise CWP becomes the target.
- Write during a successful Save/Restore uses the NEW CWP to map `RW`, so the result lands in the new window.
- `Save` and `Restore` both high in one cycle: neither takes effect; no trap. A write in that cycle uses the current CWP.
- `WimLd` together with Save/Restore: the trap check uses the OLD WIM; WIM updates on the same edge.
- CWP arithmetic wraps naturally modulo `NWINDOWS` (width `$clog2(NWINDOWS)`).
- `BYPASS`=1:
  - A read port selects `PW` when `LE`=1, the selector equals `RW`, `RW`≠0, and no Save/Restore is requested that cycle.
  - Otherwise the read port shows the stored value.

## Timing
- Reset on a `Rst_n`=0 rising edge:
  - all physical registers = 0, CWP = 0, WIM = 0, `TrapOvf` = `TrapUnf` = 0.
  - Reset overrides `LE`, `Save`, `Restore` and `WimLd` in the same cycle.
  - Reset asserted during a trap pulse clears the pulse at that edge.
- Read latency: 0 cycles (combinational).
- With `BYPASS`=0, write-to-read latency is 1 edge.
- CWP and WIM are visible one edge after request. Traps are registered, high for exactly one cycle after the offending edge.
- Back-to-back Saves are legal every cycle. Each one is checked against the CWP and WIM current at its own edge.

## Test plan
- Reset: hold `Rst_n`=0 for one edge, with `LE`=1, `RW`=5, `PW`=0xDEAD_BEEF -> all 32 `RA` values read 0; CWP=0; WIM=0; traps 0.
- r0 and globals (NWINDOWS=4):
  - Write r0 = 0xFFFF_FFFF -> `PA`(RA=0) = 0.
  - Write r1 = 0x0000_00A5 at CWP=0, then Save -> CWP=3 and r1 still reads 0xA5.
- Window overlap:
  - At CWP=0 write r8 = 0x1111_1111 and r16 = 0x2222_2222, then Save -> CWP=3.
  - r24 reads 0x1111_1111; r16 reads 0.
  - Restore -> CWP=0; r16 reads 0x2222_2222.
- Overflow: WIM=4'b1000, CWP=0, Save with `LE`=1, `RW`=16, `PW`=0x3333_3333 -> CWP stays 0; `TrapOvf` high exactly one cycle; r16 unchanged.
- Underflow and wrap:
  - CWP=3, WIM=0, Restore -> CWP=0.
  - Then set WIM=4'b0010 and Restore -> `TrapUnf` one cycle; CWP stays 0.
  - `Save`=`Restore`=1 -> CWP unchanged; no trap.
- Bypass (`BYPASS`=1): `RA`=`RW`=5, `LE`=1, `PW`=0x1234_5678 -> `PA`=0x1234_5678 in the same cycle. With `BYPASS`=0, `PA` shows the old value until after the edge.
